rr_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 40 ++++
 rtl/arb_pick.sv | 41 ++++
 rtl/rr_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the rr_arbiter request/grant block.
package arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Widest supported requester vector and its index width.
    localparam int unsigned MaxReq = 32;
    localparam int unsigned MaxIdW = 5;

    // Encoded index of the set bit of a one-hot vector; 0 when the vector is empty.
    function automatic logic [MaxIdW-1:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
        logic [MaxIdW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (oh[i]) idx = idx | MaxIdW'(i);
        end
        return idx;
    endfunction

    // Rotate the low n bits of v left by sh places (sh < n); bits at and above n read as 0.
    function automatic logic [MaxReq-1:0] rotl(input logic [MaxReq-1:0] v,
                                               input int unsigned sh,
                                               input int unsigned n);
        logic [MaxReq-1:0] res;
        int unsigned       k;
        res = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (i < n) begin
                k = i + sh;
                if (k >= n) k = k - n;
                res[MaxIdW'(k)] = v[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority from index 0, or a rotating scan from ptr.
module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic [ID_W-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    win_onehot,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    logic [N-1:0]      cand;
    logic [MaxReq-1:0] rot;
    logic [MaxReq-1:0] rot_first;
    logic [MaxIdW-1:0] rot_idx;
    int unsigned       base;
    int unsigned       shift;
    int unsigned       sum;

    // Rotate so the scan start sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        cand      = req & mask;
        base      = mode ? 32'(ptr) : 32'd0;
        shift     = (base == 0) ? 32'd0 : N - base;
        rot       = rotl(MaxReq'(cand), shift, N);
        rot_first = rot & (~rot + MaxReq'(1));
        rot_idx   = onehot_to_idx(rot_first);
        sum       = 32'(rot_idx) + base;
        if (sum >= N) sum = sum - N;
        any        = |cand;
        win_id     = ID_W'(sum);
        win_onehot = '0;
        if (any) win_onehot[win_id] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way request/grant arbiter with fixed or round-robin priority, zero-bubble handoff
// and optional maximum-hold pre-emption. All outputs are registered.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned MAX_HOLD    = 0,
    parameter int unsigned HOLD_W      = 8,
    parameter int unsigned ID_W        = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            preempt
);

    localparam bit                PreemptEn = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HoldLimit = PreemptEn ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [HOLD_W-1:0] HoldMax   = '1;

    arb_state_e        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              valid_q, valid_d;
    logic              preempt_q, preempt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N-1:0]    pick_mask;
    logic [N-1:0]    win_onehot;
    logic [ID_W-1:0] win_id;
    logic            win_any;
    logic            owner_req;
    logic            others;
    logic            take_win;

    arb_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req        (req),
        .mask       (pick_mask),
        .ptr        (ptr_q),
        .mode       (ROUND_ROBIN),
        .win_onehot (win_onehot),
        .win_id     (win_id),
        .any        (win_any)
    );

    // Next-state decision: hold, hand off (release or pre-emption), or fall back to idle.
    always_comb begin
        owner_req = |(req & gnt_q);
        others    = |(req & ~gnt_q);
        // The current owner never competes on a handoff; idle considers everyone.
        pick_mask = (state_q == StGrant) ? ~gnt_q : '1;

        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        take_win  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_any) take_win = 1'b1;
            end
            StGrant: begin
                if (!owner_req) begin
                    // A release wins over a simultaneous hold expiry, so preempt stays low.
                    if (win_any) begin
                        take_win = 1'b1;
                    end else begin
                        state_d  = StIdle;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        hold_d   = '0;
                    end
                end else if (PreemptEn && (hold_q == HoldLimit) && others) begin
                    take_win  = 1'b1;
                    preempt_d = 1'b1;
                end else if (others && (hold_q != HoldMax)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (take_win) begin
            state_d  = StGrant;
            gnt_d    = win_onehot;
            gnt_id_d = win_id;
            hold_d   = '0;
            ptr_d    = (ROUND_ROBIN && (32'(win_id) != N - 1)) ? win_id + ID_W'(1) : '0;
        end

        valid_d = |gnt_d;
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios on several configurations and a randomised
// run on N=8 (round-robin and fixed) checked against a behavioural model.
module tb_rr_arbiter;

    localparam int NCFG = 6;
    // Configurations: 0 N4 RR, 1 N4 fixed, 2 N4 RR hold3, 3 N5 RR, 4 N8 RR hold4, 5 N8 fixed hold4
    localparam logic [NCFG-1:0][7:0] CfgN  = {8'd8, 8'd8, 8'd5, 8'd4, 8'd4, 8'd4};
    localparam logic [NCFG-1:0]      CfgRr = 6'b011101;
    localparam logic [NCFG-1:0][7:0] CfgMh = {8'd4, 8'd4, 8'd0, 8'd3, 8'd0, 8'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] reqs [NCFG];
    logic [38:0] obs  [NCFG];  // {preempt, gnt_valid, gnt_id[4:0], gnt[31:0]}

    int          n_tests;
    int          n_fail;
    logic [38:0] exp_q [$];

    int m_own  [NCFG];
    int m_ptr  [NCFG];
    int m_hold [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned Nn = int'(CfgN[g]);
        localparam int unsigned Iw = $clog2(Nn);
        logic [Nn-1:0] gnt;
        logic [Iw-1:0] gnt_id;
        logic          gnt_valid;
        logic          preempt;
        rr_arbiter #(
            .N           (Nn),
            .ROUND_ROBIN (CfgRr[g]),
            .MAX_HOLD    (int'(CfgMh[g])),
            .HOLD_W      (8),
            .ID_W        (Iw)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (reqs[g][Nn-1:0]),
            .gnt       (gnt),
            .gnt_id    (gnt_id),
            .gnt_valid (gnt_valid),
            .preempt   (preempt)
        );
        assign obs[g] = {preempt, gnt_valid, 5'(gnt_id), 32'(gnt)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected observation for a grant vector; gnt_id is derived from the one-hot bit.
    function automatic logic [38:0] ob(input bit pre, input logic [31:0] g);
        logic [4:0] id = '0;
        for (int i = 0; i < 32; i++) if (g[i]) id = 5'(i);
        return {pre, |g, id, g};
    endfunction

    // gnt_id is only meaningful while a grant is held.
    function automatic logic [38:0] cmp_mask(input logic [38:0] e);
        return e[37] ? '1 : ~(39'h1F << 32);
    endfunction

    function automatic int pick(input logic [31:0] r, input int n, input int start);
        for (int i = 0; i < n; i++) begin
            int k = (start + i) % n;
            if (((r >> k) & 32'h1) != 0) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NCFG; g++) begin
            m_own[g]  = -1;
            m_ptr[g]  = 0;
            m_hold[g] = 0;
        end
    endtask

    // Advance the reference model by one edge for requests r; returns the expected observation.
    task automatic model_step(input int g, input logic [31:0] r, output logic [38:0] e);
        int          n   = int'(CfgN[g]);
        int          mh  = int'(CfgMh[g]);
        bit          rr  = CfgRr[g];
        int          own = m_own[g];
        int          st  = rr ? m_ptr[g] : 0;
        int          w   = -1;
        bit          pre = 1'b0;
        logic [31:0] oth = r;
        if (own >= 0) oth = r & ~(32'h1 << own);
        if (own < 0) begin
            w = pick(r, n, st);
        end else if (((r >> own) & 32'h1) == 0) begin
            w = pick(oth, n, st);
            if (w < 0) begin
                m_own[g]  = -1;
                m_hold[g] = 0;
            end
        end else if (mh > 0 && m_hold[g] == mh - 1 && oth != 0) begin
            w   = pick(oth, n, st);
            pre = 1'b1;
        end else if (oth != 0 && m_hold[g] < 255) begin
            m_hold[g]++;
        end
        if (w >= 0) begin
            m_own[g]  = w;
            m_hold[g] = 0;
            if (rr) m_ptr[g] = (w + 1) % n;
        end
        e = (m_own[g] < 0) ? 39'h0 : ob(pre, 32'h1 << m_own[g]);
    endtask

    task automatic test_reset();
        logic [38:0] e;
        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) reqs[g] = '0;
        for (int g = 0; g < NCFG; g++) exp_q.push_back(39'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs[g] !== e) begin
                n_fail++;
                $display("FAIL reset cfg %0d: got %h, expected %h", g, obs[g], e);
            end
        end
    endtask

    task automatic test_rr_rotation();
        logic [31:0] r_tab [6];
        logic [31:0] g_tab [6];
        logic [38:0] e;
        r_tab = '{32'hF, 32'hE, 32'hD, 32'hB, 32'h7, 32'h0};
        g_tab = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1, 32'h0};
        for (int k = 0; k < 6; k++) begin
            reqs[0] = r_tab[k];
            exp_q.push_back(ob(1'b0, g_tab[k]));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ((obs[0] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
                n_fail++;
                $display("FAIL rr_rotation step %0d: got %h, expected %h", k, obs[0], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r_tab   [4];
        logic [31:0] g_tab   [4];
        bit          rst_tab [4];
        logic [38:0] e;
        r_tab   = '{32'h4, 32'h4, 32'hF, 32'h0};
        g_tab   = '{32'h4, 32'h0, 32'h1, 32'h0};
        rst_tab = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            rst     = rst_tab[k];
            reqs[0] = r_tab[k];
            exp_q.push_back(ob(1'b0, g_tab[k]));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            // After a reset gnt_id must read 0 as well, so compare every field there.
            if ((obs[0] & (rst_tab[k] ? '1 : cmp_mask(e))) !==
                (e & (rst_tab[k] ? '1 : cmp_mask(e)))) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h, expected %h", k, obs[0], e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        logic [31:0] r_tab [7];
        logic [31:0] g_tab [7];
        logic [38:0] e;
        r_tab = '{32'hA, 32'h8, 32'h0, 32'hF, 32'hE, 32'hD, 32'h0};
        g_tab = '{32'h2, 32'h8, 32'h0, 32'h1, 32'h2, 32'h1, 32'h0};
        for (int k = 0; k < 7; k++) begin
            reqs[1] = r_tab[k];
            exp_q.push_back(ob(1'b0, g_tab[k]));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ((obs[1] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
                n_fail++;
                $display("FAIL fixed_prio step %0d: got %h, expected %h", k, obs[1], e);
            end
        end
    endtask

    task automatic test_preempt();
        logic [31:0] r_tab [21];
        logic [31:0] g_tab [21];
        bit          p_tab [21];
        logic [38:0] e;
        r_tab = '{5, 5, 5, 5, 5, 5, 5, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 5, 5, 4, 0};
        g_tab = '{1, 1, 1, 4, 4, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 4, 0};
        p_tab = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 21; k++) begin
            reqs[2] = r_tab[k];
            exp_q.push_back(ob(p_tab[k], g_tab[k]));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ((obs[2] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
                n_fail++;
                $display("FAIL preempt step %0d: got %h, expected %h", k, obs[2], e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r_tab [9];
        logic [31:0] g_tab [9];
        logic [38:0] e;
        r_tab = '{32'h08, 32'h00, 32'h03, 32'h00, 32'h03, 32'h00, 32'h10, 32'h00, 32'h03};
        g_tab = '{32'h08, 32'h00, 32'h01, 32'h00, 32'h02, 32'h00, 32'h10, 32'h00, 32'h01};
        for (int k = 0; k < 9; k++) begin
            reqs[3] = r_tab[k];
            exp_q.push_back(ob(1'b0, g_tab[k]));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ((obs[3] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
                n_fail++;
                $display("FAIL ptr_wrap step %0d: got %h, expected %h", k, obs[3], e);
            end
        end
        reqs[3] = '0;
    endtask

    task automatic test_random();
        logic [38:0] e;
        logic [38:0] got;
        logic [31:0] prev [NCFG];
        int          waitc [8];
        int          max_wait = 0;
        int          bound = 8 * (4 + 1);
        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) reqs[g] = '0;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        for (int g = 4; g < 6; g++) begin
            n_tests++;
            if (obs[g] !== 39'h0) begin
                n_fail++;
                $display("FAIL random_reset cfg %0d: got %h, expected 0", g, obs[g]);
            end
        end
        for (int c = 0; c < 10000; c++) begin
            for (int g = 4; g < 6; g++) begin
                reqs[g] = (reqs[g] ^ ($urandom & $urandom & $urandom)) & 32'hFF;
                prev[g] = reqs[g];
                model_step(g, reqs[g], e);
                exp_q.push_back(e);
            end
            tick();
            for (int g = 4; g < 6; g++) begin
                e   = exp_q.pop_front();
                got = obs[g];
                n_tests++;
                if ((got & cmp_mask(e)) !== (e & cmp_mask(e))) begin
                    n_fail++;
                    $display("FAIL random_model cfg %0d cycle %0d: got %h, expected %h",
                             g, c, got, e);
                end
                n_tests++;
                if ($countones(got[31:0]) > 1 || got[37] !== (|got[31:0]) ||
                    (got[31:0] & ~prev[g]) != 0 ||
                    (got[37] && (32'h1 << got[36:32]) != got[31:0])) begin
                    n_fail++;
                    $display("FAIL random_invariant cfg %0d cycle %0d: got %h, req %h",
                             g, c, got, prev[g]);
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (prev[4][i] && !obs[4][i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > max_wait) max_wait = waitc[i];
            end
        end
        n_tests++;
        if (max_wait > bound) begin
            n_fail++;
            $display("FAIL rr_starvation: longest wait %0d cycles, allowed %0d", max_wait, bound);
        end
        for (int g = 0; g < NCFG; g++) reqs[g] = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int g = 0; g < NCFG; g++) reqs[g] = '0;
        model_reset();
        test_reset();
        test_rr_rotation();
        test_reset_mid();
        test_fixed();
        test_preempt();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
